// File: rtl/tx_frame_pkg.sv
// rtl/tx_frame_pkg.sv - shared definitions for the UART transmit framer
//
// Contents:
//   tx_frame_state_t : framer FSM states (IDLE, START, DATA, PARITY, STOP)
//   cnt_width()      : bit-period counter width, $clog2(CLKS_PER_BIT) bits
//   idx_width()      : bit-index width, $clog2(DATA_BITS+1) bits
package tx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_frame_state_t;

  // CLKS_PER_BIT is at least 2, so this is never below 1 bit.
  function automatic int cnt_width(input int clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

  // Wide enough to index every data bit and every stop bit.
  function automatic int idx_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/tx_baud_tick.sv
// rtl/tx_baud_tick.sv - bit-period counter with end-of-bit strobe
//
// Counts 0..CLKS_PER_BIT-1 and wraps; o_last is high in the final cycle of
// each bit period. i_clear forces the count back to 0 on the next edge.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   i_clear : restart the bit period
//   o_last  : high while the counter sits at CLKS_PER_BIT-1
module tx_baud_tick
  import tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_last
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_MAX);
  assign o_last = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tx_frame_sr.sv
// rtl/tx_frame_sr.sv - parametrised UART transmit framer
//
// Accepts a word on a valid/ready handshake and sends start bit, data bits,
// optional parity bit and stop bits, each CLKS_PER_BIT clocks long.
// Optional parity is built when TX_FRAME_PARITY_EN is defined.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   tx_data    : word to send, latched on accept
//   tx_valid   : tx_data holds a word
//   parity_odd : 1 = odd parity, 0 = even (TX_FRAME_PARITY_EN only)
//   tx_ready   : framer accepts a word this cycle
//   tx_out     : registered serial line, idles high
//   tx_busy    : frame in progress
//   frame_done : pulse in the final clock of the last stop bit
module tx_frame_sr
  import tx_frame_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int LSB_FIRST    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef TX_FRAME_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int IDX_W = idx_width(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

`ifdef TX_FRAME_PARITY_EN
  localparam tx_frame_state_t AFTER_DATA = PARITY;
`else
  localparam tx_frame_state_t AFTER_DATA = STOP;
`endif

  tx_frame_state_t      r_state;
  tx_frame_state_t      w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_adv;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_tx_out;
  logic                 w_bit_last;
  logic                 w_last_stop;
  logic                 w_accept;
  logic                 w_clear;
  logic                 w_first_bit;
  logic                 w_adv_bit;
`ifdef TX_FRAME_PARITY_EN
  logic                 r_parity;
`endif

  // The counter is held at 0 in IDLE so the start bit gets a full period,
  // and restarted on every state change.
  assign w_clear = (r_state == IDLE) || (w_state_nxt != r_state);

  tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .o_last (w_bit_last)
  );

  // Last clock of the last stop bit: the frame ends here and a new word may
  // be taken in the same cycle so frames can run back to back.
  assign w_last_stop = (r_state == STOP) && w_bit_last && (r_bit_idx == LAST_STOP_IDX);
  assign tx_ready    = (r_state == IDLE) || w_last_stop;
  assign w_accept    = tx_valid && tx_ready;
  assign frame_done  = w_last_stop;
  assign tx_busy     = (r_state != IDLE);
  assign tx_out      = r_tx_out;

  // The outgoing data bit always sits at the shift-out end of the register.
  assign w_shift_adv = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  assign w_first_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[DATA_BITS-1];
  assign w_adv_bit   = (LSB_FIRST != 0) ? w_shift_adv[0] : w_shift_adv[DATA_BITS-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_last) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_last && (r_bit_idx == LAST_DATA_IDX)) begin
          w_state_nxt = AFTER_DATA;
        end
      end
`ifdef TX_FRAME_PARITY_EN
      PARITY: begin
        if (w_bit_last) begin
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_last_stop) begin
          w_state_nxt = w_accept ? START : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
`ifdef TX_FRAME_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_shift  <= tx_data;
`ifdef TX_FRAME_PARITY_EN
        r_parity <= (^tx_data) ^ parity_odd;
`endif
      end else if ((r_state == DATA) && w_bit_last) begin
        r_shift <= w_shift_adv;
      end

      // Counts data bits in DATA and stop bits in STOP.
      if (w_state_nxt != r_state) begin
        r_bit_idx <= '0;
      end else if (w_bit_last && ((r_state == DATA) || (r_state == STOP))) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end

      // tx_out is produced from the next state so the line is registered.
      case (w_state_nxt)
        START: r_tx_out <= 1'b0;
        DATA: begin
          if (r_state == START) begin
            r_tx_out <= w_first_bit;
          end else if (w_bit_last) begin
            r_tx_out <= w_adv_bit;
          end
        end
`ifdef TX_FRAME_PARITY_EN
        PARITY: r_tx_out <= r_parity;
`endif
        default: r_tx_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_sr.sv
// tb/tb_tx_frame_sr.sv - self-checking bench for tx_frame_sr
module tb_tx_frame_sr;

  localparam int C  = 4;
  localparam int DB = 8;
`ifdef TX_FRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data    [3];
  logic       tx_valid   [3];
  logic       tx_ready   [3];
  logic       tx_out     [3];
  logic       tx_busy    [3];
  logic       frame_done [3];
`ifdef TX_FRAME_PARITY_EN
  logic       parity_odd [3];
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Instance 0: LSB first, 1 stop. Instance 1: MSB first. Instance 2: 2 stops.
  tx_frame_sr #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(C), .LSB_FIRST(1)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
`ifdef TX_FRAME_PARITY_EN
    .parity_odd(parity_odd[0]),
`endif
    .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .frame_done(frame_done[0]));

  tx_frame_sr #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(C), .LSB_FIRST(0)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
`ifdef TX_FRAME_PARITY_EN
    .parity_odd(parity_odd[1]),
`endif
    .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .frame_done(frame_done[1]));

  tx_frame_sr #(.DATA_BITS(DB), .STOP_BITS(2), .CLKS_PER_BIT(C), .LSB_FIRST(1)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
`ifdef TX_FRAME_PARITY_EN
    .parity_odd(parity_odd[2]),
`endif
    .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .frame_done(frame_done[2]));

  function automatic int stop_bits_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic bit lsb_first_of(input int d);
    return (d != 1);
  endfunction

  task automatic set_parity(input int d, input logic podd);
`ifdef TX_FRAME_PARITY_EN
    parity_odd[d] = podd;
`else
    if (podd === 1'bx) $display("note: parity_odd unknown on instance %0d", d);
`endif
  endtask

  task automatic check_idle(input int d, input string tag);
    vectors++;
    if (tx_out[d] !== 1'b1 || tx_ready[d] !== 1'b1 || tx_busy[d] !== 1'b0 || frame_done[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s dut%0d idle: out=%b ready=%b busy=%b done=%b, required out=1 ready=1 busy=0 done=0",
               tag, d, tx_out[d], tx_ready[d], tx_busy[d], frame_done[d]);
    end
  endtask

  // Entered at a negedge. Unless pre is set, offers data and lets the next
  // rising edge accept it. Every cycle of the frame is compared with a bit
  // list built from the framing rules. With hold set, tx_valid stays high
  // and nxt is offered so the next frame is accepted in the last stop clock.
  task automatic run_frame(input int d, input logic [7:0] data, input logic podd,
                           input bit pre, input bit hold, input logic [7:0] nxt,
                           input logic nxt_podd, input string tag);
    logic bits[$];
    int   n;
    bit   exp_end;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(lsb_first_of(d) ? data[i] : data[DB-1-i]);
    if (P == 1) bits.push_back((^data) ^ podd);
    for (int i = 0; i < stop_bits_of(d); i++) bits.push_back(1'b1);
    n = bits.size() * C;

    if (!pre) begin
      tx_data[d]  = data;
      set_parity(d, podd);
      tx_valid[d] = 1'b1;
      vectors++;
      if (tx_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s dut%0d ready_before_accept: got %b required 1", tag, d, tx_ready[d]);
      end
      @(negedge clk);
    end

    if (hold) begin
      tx_data[d] = nxt;
      set_parity(d, nxt_podd);
    end else begin
      tx_valid[d] = 1'b0;
      tx_data[d]  = ~data;
      set_parity(d, ~podd);
    end

    for (int k = 0; k < n; k++) begin
      exp_end = (k == n - 1);
      vectors++;
      if (tx_out[d] !== bits[k / C] || tx_busy[d] !== 1'b1 ||
          frame_done[d] !== exp_end || tx_ready[d] !== exp_end) begin
        miscompares++;
        $display("FAIL %s dut%0d clk%0d: out=%b busy=%b done=%b ready=%b, required out=%b busy=1 done=%b ready=%b",
                 tag, d, k, tx_out[d], tx_busy[d], frame_done[d], tx_ready[d],
                 bits[k / C], exp_end, exp_end);
      end
      @(negedge clk);
    end

    if (!hold) check_idle(d, tag);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) check_idle(d, "reset");
  endtask

  task automatic test_lsb_first();
    run_frame(0, 8'hA5, 1'b0, 0, 0, 8'h00, 1'b0, "lsb_a5");
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(0, 8'($urandom), 1'($urandom), 0, 0, 8'h00, 1'b0, "lsb_rand");
    end
  endtask

  task automatic test_parity();
    run_frame(0, 8'h07, 1'b0, 0, 0, 8'h00, 1'b0, "par_even_07");
    run_frame(0, 8'h07, 1'b1, 0, 0, 8'h00, 1'b0, "par_odd_07");
    run_frame(0, 8'h00, 1'b1, 0, 0, 8'h00, 1'b0, "par_odd_00");
  endtask

  task automatic test_msb_first();
    run_frame(1, 8'h80, 1'b0, 0, 0, 8'h00, 1'b0, "msb_80");
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 8'($urandom), 1'($urandom), 0, 0, 8'h00, 1'b0, "msb_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic       p;
    run_frame(0, 8'h11, 1'b0, 0, 1, 8'h22, 1'b1, "b2b_11");
    run_frame(0, 8'h22, 1'b1, 1, 0, 8'h00, 1'b0, "b2b_22");
    w = 8'($urandom);
    p = 1'($urandom);
    run_frame(2, 8'h3C, 1'b0, 0, 1, w, p, "b2b_2stop_a");
    run_frame(2, w, p, 1, 0, 8'h00, 1'b0, "b2b_2stop_b");
  endtask

  task automatic test_reset_mid_frame();
    tx_data[0]  = 8'h5A;
    set_parity(0, 1'b0);
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (11) @(negedge clk);
    vectors++;
    if (tx_busy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid busy_before: got %b required 1", tx_busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_mid_edge");
    rst = 1'b0;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      check_idle(0, "rst_mid_after");
    end
    run_frame(0, 8'hC3, 1'b1, 0, 0, 8'h00, 1'b0, "rst_mid_new");
  endtask

  task automatic test_two_stop();
    run_frame(2, 8'hF0, 1'b0, 0, 0, 8'h00, 1'b0, "stop2_f0");
    for (int i = 0; i < 3; i++) begin
      run_frame(2, 8'($urandom), 1'($urandom), 0, 0, 8'h00, 1'b0, "stop2_rand");
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tx_data[d]  = 8'h00;
      tx_valid[d] = 1'b0;
      set_parity(d, 1'b0);
    end
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_lsb_first();
    test_parity();
    test_msb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_frame_sr.md
# tx_frame_sr

Parametrised UART transmit framer, the successor to the fixed 8-bit transmit shift register. It accepts a data word through a valid/ready handshake and serialises it as start bit, data bits, optional parity bit and stop bits. It contains its own bit-period timer, so it needs no external edge/enable pulses. It sits between the host-side command/response logic and the serial TX pin.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be ≥ 2.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit DATA_BITS-1 first.

Ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- tx_data, input, DATA_BITS: word to send; sampled only on accept.
- tx_valid, input, 1: tx_data holds a word to send.
- tx_ready, output, 1: framer can accept a word this cycle.
- parity_odd, input, 1: 1 selects odd parity, 0 selects even; sampled on accept. Present only with TX_FRAME_PARITY_EN.
- tx_out, output, 1: serial line; idles high.
- tx_busy, output, 1: a frame is in progress.
- frame_done, output, 1: one-cycle pulse in the final clk of the last stop bit.

## Operation
- Accept occurs when tx_valid and tx_ready are both high on a rising edge. On accept, tx_data and parity_odd are latched into an internal shift register. Later changes on either input have no effect on the frame in progress.
- FSM states are IDLE, START, DATA, PARITY, STOP. Each non-IDLE bit lasts exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1. The counter resets to 0 on accept and on every state change.
- IDLE → START on accept. START → DATA after one bit period. DATA → PARITY (or STOP when parity is compiled out) after DATA_BITS bit periods. PARITY → STOP after one bit period. STOP → IDLE after STOP_BITS bit periods.
- tx_out by state:
  - IDLE: 1.
  - START: 0.
  - DATA: current shift-register bit. Shift right when LSB_FIRST=1, left when LSB_FIRST=0. The shift happens on the last counter cycle of each bit.
  - PARITY: XOR of all latched data bits, inverted when parity_odd is set.
  - STOP: 1.
- tx_ready is high in IDLE. It is also high in the final clk of the last stop bit. An accept in that cycle goes directly to START with no idle cycle between frames. frame_done still pulses in that cycle.
- tx_busy is high in every state except IDLE.

## Timing
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, frame_done=0. The FSM returns to IDLE, the counters clear and the shift register clears. Reset takes effect on the first rising edge where rst=1.
- Reset in the middle of a frame aborts the frame. tx_out is 1 from the next edge on, no frame_done pulse is produced, and the latched word is dropped.
- The start bit appears on tx_out in the cycle after accept, so latency is 1 clk.
- Frame length is N = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 with parity compiled in and 0 without. tx_busy stays high for N·CLKS_PER_BIT cycles.
- tx_out is a registered output and is glitch-free.
- tx_valid may be held high across frames. At most one accept happens per frame.

## Configuration
- TX_FRAME_PARITY_EN defined: the PARITY state and the parity_odd port exist, and P = 1.
- TX_FRAME_PARITY_EN undefined: no parity logic and no parity_odd port. DATA transitions directly to STOP, and P = 0.

## Structure
- tx_frame_pkg holds the shared definitions:
  - the state enum tx_frame_state_t (IDLE, START, DATA, PARITY, STOP);
  - the counter-width helper constant, $clog2(CLKS_PER_BIT) bits;
  - the bit-index width constant, $clog2(DATA_BITS+1) bits.
- One sub-module, tx_baud_tick: a clear-able counter from 0 to CLKS_PER_BIT-1 that outputs a last-cycle strobe. It uses the same clk/rst as the parent.

## Test plan
All scenarios use DATA_BITS=8, CLKS_PER_BIT=4.
1. LSB_FIRST=1, no parity, accept 0xA5 → tx_out is 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 for 4 clk each, then 1 for 4 clk. tx_busy is high for 40 clk, and frame_done pulses at clk 40.
2. Parity on, parity_odd=0, data 0x07 → parity bit 1. With parity_odd=1 → parity bit 0. The frame is 44 clk.
3. LSB_FIRST=0, data 0x80 → first data bit 1, remaining seven bits 0.
4. tx_valid held high with words 0x11 then 0x22 → second accept lands in the final stop cycle of the first frame. The second start bit follows with no high gap, and frame_done pulses exactly once per frame.
5. rst asserted at clk 12 of a frame → tx_out=1, tx_ready=1, tx_busy=0 on the next edge, and no frame_done. A new accept afterwards produces a complete, correct frame.
6. STOP_BITS=2 → the stop period is 8 clk high. tx_ready does not rise until the last clk of the second stop bit.
